data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-addressed data memory that sits on the responder side of the datapath's data-memory port. It services the datapath's read and write strobes against internal storage and returns read data one cycle later. After every reset it zero-fills its storage with a sweep state machine, and it records the first illegal access it sees. It replaces the behavioural data memory in system-level simulation and is the synthesizable target memory.

## Interface
- AW, 10, log2 of depth in 32-bit words (depth = 2^AW)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- addr  in  32  byte address from datapath (dataMem_addr)
- wdata  in  32  write data from datapath (datapath's dataMem_dout)
- rd  in  1  read strobe, one access per cycle
- wr  in  1  write strobe, one access per cycle
- rdata  out  32  registered read data to datapath (datapath's dataMem_din)
- ready  out  1  high once the post-reset clear sweep is complete
- err  out  1  sticky flag for an illegal access
- err_addr  out  32  addr of the first illegal access since reset

## Operation
- States:
  - CLEAR: entered on reset.
    - Writes 0 to mem[clr_cnt] each cycle and increments the AW-bit counter clr_cnt.
    - After the cycle that writes index 2^AW-1, moves to RUN.
  - RUN: services rd/wr. No exit except reset.
- Index = addr[AW+1:2].
- An access is legal only when addr[1:0]==0 and addr[31:AW+2]==0.
- In CLEAR, rd/wr are ignored. The sweep does not stall and rdata is unchanged. err is not set.
- RUN write (wr=1, legal): mem[index] <= wdata at the edge.
- RUN read (rd=1, legal): rdata <= mem[index] at the edge. rdata then holds until the next accepted read.
- rd and wr both high on the same legal address: the write commits, and rdata returns the pre-write (old) contents.
- Illegal access in RUN (rd or wr):
  - The memory is not modified.
  - A read loads rdata <= 0.
  - err <= 1.
  - err_addr <= addr, only if err was 0 before this edge.
- rd=wr=0: no state change.
- err and err_addr clear only on reset.
- Async reset at any time, including mid-sweep or mid-access:
  - Immediately forces state=CLEAR, clr_cnt=0, ready=0, rdata=0, err=0, err_addr=0.
  - An in-flight access is abandoned.
  - The sweep restarts from index 0 after reset deasserts.

## Timing
- Reset values: rdata=0, ready=0, err=0, err_addr=0.
- Clear sweep: 2^AW cycles after reset deasserts.
  - ready rises at the edge following the write of the last index.
  - ready is registered, so first-serviced-access timing depends only on ready.
- Read latency: 1 cycle. rd is sampled at edge N, and rdata is valid after edge N and stable through edge N+1.
- Write latency: 0 cycles. A write at edge N is visible to a read sampled at edge N+1.
- Throughput: one access per cycle, back-to-back, with no stall or handshake once ready=1.
- err and err_addr update at the same edge as the offending access.

## Test plan
- AW=4, release reset, hold rd=1 at addr 0x0 throughout:
  - ready=0 for exactly 16 cycles, then 1.
  - rdata stays 0 during CLEAR.
  - First serviced read returns 0x00000000.
- Write 0x12345678 to 0x8, then read 0x8 on the next cycle: rdata=0x12345678 one cycle after the read edge. Back-to-back reads of 0x0/0x4/0x8 stream 0, 0, 0x12345678 on consecutive cycles.
- Preload 0xAAAA5555 at 0x10, then apply rd=wr=1 at 0x10 with wdata=0x0F0F0F0F:
  - That access returns rdata=0xAAAA5555.
  - The next read returns 0x0F0F0F0F.
- AW=4: write to 0x42 (misaligned), then read 0x40 (out of range):
  - err=1 after the first access.
  - err_addr=0x00000042 and holds after the second access.
  - The read returns rdata=0.
  - All memory contents are unchanged.
- Assert reset for 1 cycle mid-sweep, and again after data was written:
  - ready, err and rdata drop immediately.
  - The sweep reruns a full 16 cycles.
  - Previously written 0x8 reads back 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory on the responder side of the datapath's data port.
// Zero-fills itself after every reset, then serves one read/write per cycle and flags the first illegal access.
module data_mem_responder #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] err_addr
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt, clr_cnt_next;
  logic [31:0]   mem [2**AW];

  logic [AW-1:0] index;
  logic          legal;
  logic          run;
  logic          bad_access;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wd;

  assign index      = addr[AW+1:2];
  assign legal      = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
  assign run        = (state == RUN);
  assign bad_access = run && (rd || wr) && !legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      ready   <= (state_next == RUN);
    end
  end

  // The sweep owns the single write port while clearing; afterwards the datapath does.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next   = state;
    clr_cnt_next = clr_cnt;
    mem_we       = 1'b0;
    mem_idx      = index;
    mem_wd       = wdata;
    case (state)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_idx      = clr_cnt;
        mem_wd       = '0;
        clr_cnt_next = clr_cnt + AW'(1);
        if (clr_cnt == '1) state_next = RUN;
      end
      RUN: begin
        mem_we = wr && legal;
      end
      default: state_next = CLEAR;
    endcase
  end

  // NOTE: storage has no reset term; the post-reset sweep clears it so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // Reading the array here with <= yields the pre-write word on a simultaneous rd/wr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (run && rd) begin
      rdata <= legal ? mem[index] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (bad_access) begin
      err <= 1'b1;
      if (!err) err_addr <= addr;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at AW=4: clear sweep, read/write vectors, illegal accesses, resets.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_err_addr;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  data_mem_responder #(.AW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .rd       (rd),
    .wr       (wr),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .err_addr (err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges until ready rises; rdata must stay 0 throughout the sweep.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
      check("clear_rdata", rdata, 32'h0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] exp;
    rd    = v.rd;
    wr    = v.wr;
    addr  = v.addr;
    wdata = v.wdata;
    if (v.rd) exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    #1;
    if (v.rd) begin
      exp = exp_q.pop_front();
      check({tag, "_rdata"}, rdata, exp);
      last_rd = exp;
    end else begin
      check({tag, "_hold"}, rdata, last_rd);
    end
    check({tag, "_err"}, 32'(err), 32'(v.exp_err));
    check({tag, "_err_addr"}, err_addr, v.exp_err_addr);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // Asserts reset mid-cycle for one edge and checks the asynchronous clear.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_ready"}, 32'(ready), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_err_addr"}, err_addr, 32'h0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_rd = 32'h0;
  endtask

  initial begin
    int   n;
    vec_t v;

    //          rd    wr    addr        wdata         exp_rdata     err   err_addr
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hAAAA_5555, 32'h0,         1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0F0F_0F0F, 32'hAAAA_5555, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0F0F_0F0F, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_003C, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_003C, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0004, 32'h5555_5555, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0042, 32'hBAD0_BAD0, 32'h0,         1'b1, 32'h42};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b1, 32'h42};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 32'h42};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b1, 32'h42};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_003C, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'h42};

    reset   = 1'b1;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;
    last_rd = 32'h0;
    #12;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);

    // Sweep with a read held at address 0 the whole time.
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd    = 1'b1;
    addr  = 32'h0;
    wait_ready(n);
    check("sweep_len", 32'(n), 32'd16);
    @(posedge clk);
    #1;
    check("first_read", rdata, 32'h0);
    check("first_read_ready", 32'(ready), 32'h1);
    rd = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset after data was written, then again in the middle of the sweep.
    pulse_reset("rst_data");
    repeat (5) @(posedge clk);
    check("mid_sweep_ready", 32'(ready), 32'h0);
    pulse_reset("rst_sweep");
    wait_ready(n);
    check("resweep_len", 32'(n), 32'd16);

    v = '{1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 32'h0};
    run_vec(v, "post_rst_8");
    v = '{1'b1, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0, 32'h0};
    run_vec(v, "post_rst_3c");
    v = '{1'b1, 1'b0, 32'h1_0000_0 << 4, 32'h0, 32'h0, 1'b1, 32'h0100_0000};
    run_vec(v, "post_rst_oor");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
